// File: rtl/line_window_loader.sv
// Loads a FILTER_SIZE x IMAGE_WIDTH pixel window from image BRAM, issuing one read per cycle.
// Optional LOAD_CHECKSUM_EN adds a 32-bit running sum of every pixel written during a load.
module line_window_loader #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int FILTER_SIZE  = 3,
    parameter int PIXEL_W      = 8,
    parameter int BRAM_LATENCY = 2,
    parameter int ADDR_W       = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [15:0]                               row_base,
    input  logic                                      incremental,
    input  logic                                      pad_mode,
    output logic                                      bram_en,
    output logic [ADDR_W-1:0]                         bram_addr,
    input  logic [PIXEL_W-1:0]                        bram_data,
    output logic [FILTER_SIZE*IMAGE_WIDTH*PIXEL_W-1:0] window_flat,
    output logic                                      busy,
    output logic                                      done
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [31:0]                               checksum
`endif
);

    // state | meaning
    // IDLE  | waiting for start
    // ISSUE | one BRAM read (or pad slot) per cycle
    // DRAIN | last reads in flight, waiting for tag pipeline to empty
    // DONE  | one-cycle completion pulse

    localparam int ROW_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int N_FULL = FILTER_SIZE * IMAGE_WIDTH;
    localparam int CNT_W = $clog2(N_FULL + 1);
    localparam int LAT = BRAM_LATENCY;
    localparam logic [LAT-1:0] LAST_MASK = LAT'(1) << (LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [15:0]      row_base_q;
    logic             pad_q;
    logic [CNT_W-1:0] issue_left;
    logic [ROW_W-1:0] issue_row;
    logic [COL_W-1:0] issue_col;
    logic             accept;
    logic             last_issue;

    logic [16:0]       src_row;
    logic [16:0]       eff_row;
    logic              slot_oob;
    logic              slot_zero;
    logic [ADDR_W-1:0] slot_addr;

    logic [LAT-1:0]   pipe_vld;
    logic [LAT-1:0]   pipe_zero;
    logic [ROW_W-1:0] pipe_row [LAT];
    logic [COL_W-1:0] pipe_col [LAT];
    logic             pending;
    logic             cap_vld;
    logic [PIXEL_W-1:0] cap_pix;

    logic [PIXEL_W-1:0] win [FILTER_SIZE][IMAGE_WIDTH];

    assign accept     = (state == S_IDLE) && start;
    assign last_issue = (issue_left == CNT_W'(1));

    // source row saturates at the bottom edge; pad mode turns those slots into zero writes
    always_comb begin
        src_row   = {1'b0, row_base_q} + 17'(issue_row);
        slot_oob  = (src_row >= 17'(IMAGE_HEIGHT));
        slot_zero = slot_oob && pad_q;
        eff_row   = slot_oob ? 17'(IMAGE_HEIGHT - 1) : src_row;
        slot_addr = ADDR_W'(eff_row) * ADDR_W'(IMAGE_WIDTH) + ADDR_W'(issue_col);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN: if (!pending) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bram_en   = (state == S_ISSUE) && !slot_zero;
        bram_addr = (state == S_ISSUE) ? slot_addr : '0;
        busy      = (state == S_ISSUE) || (state == S_DRAIN);
        done      = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_base_q <= '0;
            pad_q      <= 1'b0;
            issue_left <= '0;
            issue_row  <= '0;
            issue_col  <= '0;
        end else if (accept) begin
            row_base_q <= row_base;
            pad_q      <= pad_mode;
            issue_left <= incremental ? CNT_W'(IMAGE_WIDTH) : CNT_W'(N_FULL);
            issue_row  <= incremental ? ROW_W'(FILTER_SIZE - 1) : '0;
            issue_col  <= '0;
        end else if (state == S_ISSUE) begin
            issue_left <= issue_left - CNT_W'(1);
            if (issue_col == COL_W'(IMAGE_WIDTH - 1)) begin
                issue_col <= '0;
                issue_row <= issue_row + ROW_W'(1);
            end else begin
                issue_col <= issue_col + COL_W'(1);
            end
        end
    end

    // the tag at stage LAT-1 lines up with the BRAM data for the same slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld  <= '0;
            pipe_zero <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_row[i] <= '0;
                pipe_col[i] <= '0;
            end
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_zero[i] <= pipe_zero[i-1];
                pipe_row[i]  <= pipe_row[i-1];
                pipe_col[i]  <= pipe_col[i-1];
            end
            pipe_vld[0]  <= (state == S_ISSUE);
            pipe_zero[0] <= slot_zero;
            pipe_row[0]  <= issue_row;
            pipe_col[0]  <= issue_col;
        end
    end

    assign pending = |(pipe_vld & ~LAST_MASK);
    assign cap_vld = pipe_vld[LAT-1];
    assign cap_pix = pipe_zero[LAT-1] ? '0 : bram_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < FILTER_SIZE; r++) begin
                for (int c = 0; c < IMAGE_WIDTH; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            if (accept && incremental) begin
                for (int r = 0; r < FILTER_SIZE - 1; r++) begin
                    for (int c = 0; c < IMAGE_WIDTH; c++) begin
                        win[r][c] <= win[r+1][c];
                    end
                end
            end
            if (cap_vld) begin
                win[pipe_row[LAT-1]][pipe_col[LAT-1]] <= cap_pix;
            end
        end
    end

    always_comb begin
        window_flat = '0;
        for (int r = 0; r < FILTER_SIZE; r++) begin
            for (int c = 0; c < IMAGE_WIDTH; c++) begin
                window_flat[(r*IMAGE_WIDTH+c)*PIXEL_W +: PIXEL_W] = win[r][c];
            end
        end
    end

`ifdef LOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (cap_vld) begin
            checksum <= checksum + 32'(cap_pix);
        end
    end
`endif

endmodule

// File: tb/tb_line_window_loader.sv
// Randomised bench for line_window_loader: cycle-by-cycle schedule and window contents
// are checked against a row/column model of the image and the load rules.
module tb_line_window_loader;
    localparam int W = 8;
    localparam int H = 8;
    localparam int F = 3;
    localparam int P = 8;
    localparam int L = 2;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [15:0] row_base = '0;
    logic incremental = 1'b0;
    logic pad_mode = 1'b0;
    logic bram_en;
    logic [AW-1:0] bram_addr;
    logic [P-1:0] bram_data;
    logic [F*W*P-1:0] window_flat;
    logic busy;
    logic done;
`ifdef LOAD_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int n_checks = 0;
    int n_pass = 0;
    logic [P-1:0] mem [W*H];
    int exp_win [F][W];
    longint exp_sum;
    logic [P-1:0] d1;

    always #5 clk = ~clk;

    // two-cycle BRAM; unread cycles return noise so pad slots cannot pass by accident
    always @(posedge clk) begin
        d1 <= bram_en ? mem[bram_addr] : P'($urandom);
        bram_data <= d1;
    end

    line_window_loader #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FILTER_SIZE(F),
        .PIXEL_W(P), .BRAM_LATENCY(L), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .row_base(row_base),
        .incremental(incremental), .pad_mode(pad_mode),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_data(bram_data),
        .window_flat(window_flat), .busy(busy), .done(done)
`ifdef LOAD_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    function automatic int pix(input int r, input int c);
        return int'(window_flat[(r*W+c)*P +: P]);
    endfunction

    function automatic int model_pixel(input int src, input int c, input bit pad);
        if (src >= H) return pad ? 0 : int'(mem[(H-1)*W+c]);
        return int'(mem[src*W+c]);
    endfunction

    task automatic check_window(input string tag);
        for (int r = 0; r < F; r++)
            for (int c = 0; c < W; c++)
                check($sformatf("%s win[%0d][%0d]", tag, r, c), pix(r, c), exp_win[r][c]);
    endtask

    task automatic run_load(input int rb, input bit inc, input bit pad, input bit poke);
        int n;
        int en_cnt;
        int want_en_cnt;
        int t_row;
        int src;
        int col;
        bit want_en;
        string tag;
        tag = $sformatf("load rb=%0d inc=%0d pad=%0d", rb, inc, pad);
        n = inc ? W : F*W;
        en_cnt = 0;
        want_en_cnt = 0;
        exp_sum = 0;
        if (inc)
            for (int r = 0; r < F-1; r++)
                for (int c = 0; c < W; c++)
                    exp_win[r][c] = exp_win[r+1][c];
        for (int r = (inc ? F-1 : 0); r < F; r++) begin
            for (int c = 0; c < W; c++) begin
                exp_win[r][c] = model_pixel(rb + r, c, pad);
                exp_sum += exp_win[r][c];
                if (!(pad && rb + r >= H)) want_en_cnt++;
            end
        end

        @(negedge clk);
        start = 1'b1;
        row_base = 16'(rb);
        incremental = inc;
        pad_mode = pad;
        for (int k = 1; k <= n + L + 2; k++) begin
            @(negedge clk);
            start = poke && (k == 5 || k == n + L + 1);
            if (start) begin
                row_base = 16'($urandom_range(0, 9));
                incremental = 1'($urandom);
                pad_mode = 1'($urandom);
            end
            if (k <= n) begin
                t_row = inc ? F-1 : (k-1) / W;
                col = (k-1) % W;
                src = rb + t_row;
                want_en = !(src >= H && pad);
                check($sformatf("%s cyc%0d bram_en", tag, k), bram_en, want_en);
                if (want_en)
                    check($sformatf("%s cyc%0d bram_addr", tag, k), bram_addr,
                          (src >= H ? H-1 : src) * W + col);
            end else begin
                check($sformatf("%s cyc%0d bram_en", tag, k), bram_en, 0);
            end
            check($sformatf("%s cyc%0d busy", tag, k), busy, (k <= n + L) ? 1 : 0);
            check($sformatf("%s cyc%0d done", tag, k), done, (k == n + L + 1) ? 1 : 0);
            if (bram_en) en_cnt++;
        end
        start = 1'b0;
        check({tag, " bram_en count"}, en_cnt, want_en_cnt);
        check_window(tag);
`ifdef LOAD_CHECKSUM_EN
        check({tag, " checksum"}, checksum, exp_sum);
`endif
    endtask

    task automatic run_abort(input int rb);
        @(negedge clk);
        start = 1'b1;
        row_base = 16'(rb);
        incremental = 1'b0;
        pad_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort bram_en", bram_en, 0);
        check("abort bram_addr", bram_addr, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort window zero", (window_flat == '0) ? 1 : 0, 1);
        for (int r = 0; r < F; r++)
            for (int c = 0; c < W; c++)
                exp_win[r][c] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post-release busy", busy, 0);
        check_window("post-release");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset bram_en", bram_en, 0);
        check("reset bram_addr", bram_addr, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset window zero", (window_flat == '0) ? 1 : 0, 1);
        rst = 1'b1;
        @(negedge clk);

        for (int a = 0; a < W*H; a++) mem[a] = P'(a);

        run_load(2, 1'b0, 1'b0, 1'b1);
        check("full r0c0 literal", pix(0, 0), 16);
        check("full r2c7 literal", pix(2, 7), 39);

        run_load(3, 1'b1, 1'b0, 1'b0);
        check("incr r0c0 literal", pix(0, 0), 24);
        check("incr r1c7 literal", pix(1, 7), 39);
        check("incr r2c0 literal", pix(2, 0), 40);

        run_load(6, 1'b0, 1'b0, 1'b0);
        check("edge replicate r2c3 literal", pix(2, 3), 59);

        run_load(6, 1'b0, 1'b1, 1'b1);
        check("edge zero r2c3 literal", pix(2, 3), 0);
        check("edge zero r1c3 literal", pix(1, 3), 59);

        run_load(0, 1'b0, 1'b0, 1'b0);
`ifdef LOAD_CHECKSUM_EN
        check("checksum literal", checksum, 276);
`endif

        run_abort(1);
        run_load(1, 1'b0, 1'b0, 1'b0);
        check("after abort r0c0 literal", pix(0, 0), 8);

        for (int a = 0; a < W*H; a++) mem[a] = P'($urandom);
        for (int i = 0; i < 16; i++)
            run_load($urandom_range(0, 9), 1'($urandom), 1'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
